cache_ram_ctrl: RTL and testbench

- Initiator side of the cache-to-BRAM word interface (ram_en / ram_write / ram_addr / data_to_ram / ram_rdy / data_from_ram).
- Takes one line-level request from cache control and performs either a line refill (read LINE_WORDS words) or a line write-back (write LINE_WORDS words).
- Issues one word per handshake and streams read words back to the cache data array.
- Sits between the cache FSM and the BRAM wrapper.

---
 rtl/cache_ram_ctrl.sv | 137 +++++++++++++
 tb/tb_cache_ram_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ram_ctrl.sv
// Cache-line refill / write-back initiator on the BRAM word port: one word per handshake, ram_en dropped for one cycle between words.
// Optional macro CRIT_WORD_FIRST_EN: refills start at the requested word and wrap through the line.
module cache_ram_ctrl #(
  parameter  int ADDR_W     = 12,
  parameter  int DATA_W     = 32,
  parameter  int LINE_WORDS = 8,
  localparam int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic [OFF_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rd_valid,
  output logic [OFF_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] data_to_ram,
  input  logic              ram_rdy,
  input  logic [DATA_W-1:0] data_from_ram
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      write_q;
  logic [ADDR_W-OFF_W-1:0]   line_q;
  logic [OFF_W-1:0]          off_q;
  logic [OFF_W-1:0]          cnt_q;
  logic [OFF_W-1:0]          start_off;
  logic [OFF_W-1:0]          rd_idx_q;
  logic [DATA_W-1:0]         rd_data_q;
  logic                      rd_valid_q;
  logic                      done_q;
  logic                      accept;
  logic                      word_done;
  logic                      last_word;

`ifdef CRIT_WORD_FIRST_EN
  assign start_off = req_write ? '0 : req_addr[OFF_W-1:0];
`else
  logic unused_req_off;
  assign unused_req_off = ^req_addr[OFF_W-1:0];
  assign start_off      = '0;
`endif

  assign accept    = req_ready & req_valid;
  assign word_done = ram_en & ram_rdy;
  assign last_word = (cnt_q == OFF_W'(LINE_WORDS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_ACC;
      S_ACC:   if (ram_rdy) state_d = last_word ? S_IDLE : S_GAP;
      S_GAP:   state_d = S_ACC;
      default: state_d = S_IDLE;
    endcase
  end

  // The GAP cycle keeps ram_en low so the responder re-arms before the next word.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    ram_en    = 1'b0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_ACC: begin
        busy   = 1'b1;
        ram_en = 1'b1;
      end
      S_GAP:  busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q    <= 1'b0;
      line_q     <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      if (accept) begin
        write_q <= req_write;
        line_q  <= req_addr[ADDR_W-1:OFF_W];
        off_q   <= start_off;
        cnt_q   <= '0;
      end else if (word_done) begin
        if (!write_q) begin
          rd_data_q  <= data_from_ram;
          rd_idx_q   <= off_q;
          rd_valid_q <= 1'b1;
        end
        off_q  <= off_q + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
        done_q <= last_word;
      end
    end
  end

  // wb_data follows wb_idx combinationally, so data_to_ram is stable while the offset is.
  assign wb_idx      = off_q;
  assign ram_write   = ram_en & write_q;
  assign ram_addr    = {line_q, off_q};
  assign data_to_ram = ram_write ? wb_data : '0;
  assign rd_valid    = rd_valid_q;
  assign rd_idx      = rd_idx_q;
  assign rd_data     = rd_data_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cache_ram_ctrl.sv
// Bench for cache_ram_ctrl: BRAM responder with stalls/noise, spec-level per-cycle model, literal latency and ordering checks.
module tb_cache_ram_ctrl;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic        req_ready;
  logic [2:0]  wb_idx;
  logic [31:0] wb_data;
  logic        rd_valid;
  logic [2:0]  rd_idx;
  logic [31:0] rd_data;
  logic        done;
  logic        busy;
  logic        ram_en;
  logic        ram_write;
  logic [11:0] ram_addr;
  logic [31:0] data_to_ram;
  logic        ram_rdy = 1'b0;
  logic [31:0] data_from_ram = '0;

  logic [31:0] wb_base = '0;
  assign wb_data = wb_base + {29'd0, wb_idx};

  cache_ram_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_ready(req_ready),
    .wb_idx(wb_idx), .wb_data(wb_data),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data),
    .done(done), .busy(busy),
    .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr), .data_to_ram(data_to_ram),
    .ram_rdy(ram_rdy), .data_from_ram(data_from_ram)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // BRAM responder: ready is raised on the third cycle ram_en is seen high (plus any stall).
  logic [31:0] bram    [0:4095];
  logic [31:0] ref_mem [0:4095];
  bit noise = 1'b0;
  bit rand_stall = 1'b0;
  int stall_off = -1;
  int stall_amt = 0;
  int en_cnt = 0;
  int extra = 0;

  always @(negedge clk) begin
    if (ram_en !== 1'b1) begin
      en_cnt = 0;
      ram_rdy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      data_from_ram = $urandom;
    end else begin
      if (en_cnt == 0)
        extra = (int'(ram_addr[2:0]) == stall_off) ? stall_amt : (rand_stall ? int'($urandom_range(0, 2)) : 0);
      en_cnt++;
      if (en_cnt == 3 + extra) begin
        ram_rdy = 1'b1;
        if (ram_write) bram[ram_addr] = data_to_ram;
        else data_from_ram = bram[ram_addr];
      end else begin
        ram_rdy = 1'b0;
      end
    end
  end

  function automatic int first_off(input bit w, input logic [11:0] a);
`ifdef CRIT_WORD_FIRST_EN
    return w ? 0 : int'(a[2:0]);
`else
    return 0;
`endif
  endfunction

  // Reference model: transfer progress tracked as words completed plus a one-cycle gap flag.
  bit m_busy = 0, m_gap = 0, m_write = 0;
  int m_line = 0, m_off = 0, m_words = 0;
  bit e_rdv = 0, e_done = 0;
  int e_rdidx = 0;
  logic [31:0] e_rddat = '0;
  bit en_exp;
  int acc_edge = 0;
  int lat_q[$];
  int ord_q[$];
  logic [31:0] dat_q[$];
  int done_lat = -1;

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      m_busy = 0; m_gap = 0; m_write = 0; m_line = 0; m_off = 0; m_words = 0;
      e_rdv = 0; e_done = 0;
    end else begin
      en_exp = m_busy && !m_gap;
      chk("req_ready", req_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("ram_en", ram_en, en_exp);
      chk("ram_write", ram_write, en_exp && m_write);
      chk("wb_idx", wb_idx, m_off);
      if (en_exp) begin
        chk("ram_addr", ram_addr, m_line * LW + m_off);
        if (m_write) chk("data_to_ram", data_to_ram, wb_base + m_off);
      end
      chk("rd_valid", rd_valid, e_rdv);
      if (e_rdv) begin
        chk("rd_idx", rd_idx, e_rdidx);
        chk("rd_data", rd_data, e_rddat);
      end
      chk("done", done, e_done);
      if (rd_valid === 1'b1) begin
        lat_q.push_back(cyc - acc_edge);
        ord_q.push_back(int'(rd_idx));
        dat_q.push_back(rd_data);
      end
      if (done === 1'b1) done_lat = cyc - acc_edge;

      e_rdv = 0;
      e_done = 0;
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1; m_gap = 0; m_write = req_write;
          m_line = int'(req_addr[11:3]);
          m_off = first_off(req_write, req_addr);
          m_words = 0;
          acc_edge = cyc + 1;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (ram_rdy) begin
        if (m_write) begin
          ref_mem[m_line * LW + m_off] = wb_base + m_off;
        end else begin
          e_rdv = 1;
          e_rdidx = m_off;
          e_rddat = ref_mem[m_line * LW + m_off];
        end
        m_off = (m_off + 1) % LW;
        m_words++;
        if (m_words == LW) begin
          m_busy = 0;
          e_done = 1;
        end else begin
          m_gap = 1;
        end
      end
    end
  end

  task automatic clear_logs();
    lat_q.delete();
    ord_q.delete();
    dat_q.delete();
    done_lat = -1;
  endtask

  task automatic start_req(input bit w, input logic [11:0] a, input logic [31:0] base);
    int t = 0;
    @(negedge clk);
    wb_base = base; req_write = w; req_addr = a; req_valid = 1'b1;
    while (req_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("req_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    chk("done_timeout", done, 1);
  endtask

  task automatic check_order(input string name, input int want[8]);
    chk({name, "_count"}, ord_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < ord_q.size()) begin
        chk({name, "_idx"}, ord_q[k], want[k]);
        chk({name, "_data"}, dat_q[k], 32'hA0 + want[k]);
      end
    end
  endtask

`ifdef CRIT_WORD_FIRST_EN
  int ord1[8] = '{7, 0, 1, 2, 3, 4, 5, 6};
  int ord6[8] = '{5, 6, 7, 0, 1, 2, 3, 4};
`else
  int ord1[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int ord6[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  int done_edge;

  initial begin
    for (int i = 0; i < 4096; i++) bram[i] = $urandom;
    for (int i = 0; i < 8; i++) bram[12'h008 + i] = 32'hA0 + i;
    for (int i = 0; i < 4096; i++) ref_mem[i] = bram[i];

    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_data_to_ram", data_to_ram, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_wb_idx", wb_idx, 0);
    rst = 1'b1;

    // Refill of line 1 with the standard responder
    clear_logs();
    start_req(1'b0, 12'h00F, 32'h0);
    wait_done();
    @(negedge clk);
    chk("t1_done_lat", done_lat, 31);
    chk("t1_nwords", lat_q.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < lat_q.size()) chk("t1_word_lat", lat_q[k], 3 + 4 * k);
    check_order("t1", ord1);

    // Write-back of line 2
    clear_logs();
    start_req(1'b1, 12'h010, 32'h5500);
    wait_done();
    @(negedge clk);
    chk("t2_done_lat", done_lat, 31);
    chk("t2_no_rd_valid", lat_q.size(), 0);
    for (int i = 0; i < 8; i++) chk("t2_ram_word", bram[12'h010 + i], 32'h5500 + i);

    // Responder stalls word 3 by five cycles
    stall_off = 3; stall_amt = 5;
    clear_logs();
    start_req(1'b0, 12'h018, 32'h0);
    wait_done();
    @(negedge clk);
    stall_off = -1;
    chk("t3_done_lat", done_lat, 36);
    if (lat_q.size() == 8) begin
      chk("t3_word3_lat", lat_q[3], 20);
      chk("t3_word4_lat", lat_q[4], 24);
    end else begin
      chk("t3_nwords", lat_q.size(), 8);
    end

    // Asynchronous reset in the middle of a refill
    clear_logs();
    start_req(1'b0, 12'h020, 32'h0);
    for (int t = 0; t < 200 && ord_q.size() < 3; t++) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t4_req_ready", req_ready, 1);
    chk("t4_busy", busy, 0);
    chk("t4_ram_en", ram_en, 0);
    chk("t4_ram_addr", ram_addr, 0);
    chk("t4_rd_valid", rd_valid, 0);
    chk("t4_rd_data", rd_data, 0);
    chk("t4_done", done, 0);
    repeat (3) @(negedge clk);
    chk("t4_no_done", done_lat, -1);
    rst = 1'b1;
    start_req(1'b1, 12'h028, 32'h7700);
    wait_done();
    for (int i = 0; i < 8; i++) chk("t4_wb_word", bram[12'h028 + i], 32'h7700 + i);

    // Back-to-back: req_valid held across done
    clear_logs();
    @(negedge clk);
    wb_base = 32'h0; req_write = 1'b0; req_addr = 12'h030; req_valid = 1'b1;
    wait_done();
    done_edge = cyc;
    req_write = 1'b1; req_addr = 12'h038; wb_base = 32'h9900;
    @(negedge clk);
    req_valid = 1'b0;
    chk("t5_first_done_lat", done_lat, 31);
    chk("t5_first_nwords", lat_q.size(), 8);
    chk("t5_accept_edge", acc_edge, done_edge + 1);
    clear_logs();
    wait_done();
    @(negedge clk);
    chk("t5_second_done_lat", done_lat, 31);
    for (int i = 0; i < 8; i++) chk("t5_wb_word", bram[12'h038 + i], 32'h9900 + i);

    // Refill of line 1 requested at word 5
    clear_logs();
    start_req(1'b0, 12'h00D, 32'h0);
    wait_done();
    @(negedge clk);
    check_order("t6", ord6);

    // Randomized traffic with responder noise and random stalls
    noise = 1'b1; rand_stall = 1'b1;
    for (int n = 0; n < 40; n++) begin
      start_req(1'($urandom_range(0, 1)), 12'($urandom), $urandom);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    noise = 1'b0; rand_stall = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4096; i++) chk("final_mem", bram[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
